// File: rtl/battle_front_scan.sv
// battle_front_scan
//   Walks N_UNITS friendly and N_UNITS enemy slots, one slot of each side per
//   cycle, after a start pulse. It finds the most advanced live unit on each
//   side (lowest friendly location, highest enemy location), the slot holding
//   it, and the live count. The raw fronts then get saturating offsets, and
//   contact between the adjusted fronts is flagged. Results are held until the
//   next scan's ADJUST cycle.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           begin a scan (honoured only in IDLE)
//   ack             release DONE (honoured only in DONE)
//   unit_loc/type   friendly slot i at [i*W +: W]; type 0 = empty slot
//   enemy_loc/type  enemy slots, same packing
//   friendly_front  min live friendly loc - F_OFFSET, floored at 0
//   enemy_front     max live enemy loc + E_OFFSET, capped at MAXLOC
//   *_idx, *_cnt    slot of the raw front, live unit count
//   *_valid         count > 0
//   contact         friendly_front <= enemy_front
//   busy, done      SCAN/ADJUST in progress, results ready
module battle_front_scan #(
   parameter int N_UNITS  = 16,
   parameter int LOC_W    = 9,
   parameter int TYPE_W   = 2,
   parameter int F_OFFSET = 6,
   parameter int E_OFFSET = 7,
   localparam int IDX_W   = $clog2(N_UNITS),
   localparam int CNT_W   = $clog2(N_UNITS + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        ack,
   input  logic [N_UNITS*LOC_W-1:0]    unit_loc,
   input  logic [N_UNITS*TYPE_W-1:0]   unit_type,
   input  logic [N_UNITS*LOC_W-1:0]    enemy_loc,
   input  logic [N_UNITS*TYPE_W-1:0]   enemy_type,
   output logic [LOC_W-1:0]            friendly_front,
   output logic [LOC_W-1:0]            enemy_front,
   output logic [IDX_W-1:0]            friendly_idx,
   output logic [IDX_W-1:0]            enemy_idx,
   output logic [CNT_W-1:0]            friendly_cnt,
   output logic [CNT_W-1:0]            enemy_cnt,
   output logic                        friendly_valid,
   output logic                        enemy_valid,
   output logic                        contact,
   output logic                        busy,
   output logic                        done
);

   localparam logic [LOC_W-1:0] MAXLOC   = '1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_UNITS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, ADJUST, DONE} state_t;

   state_t            state;
   logic [IDX_W-1:0]  scanIdx;

   // Working registers: initialised on start, so they carry no reset.
   logic [LOC_W-1:0]  workMin;
   logic [LOC_W-1:0]  workMax;
   logic [IDX_W-1:0]  workFIdx;
   logic [IDX_W-1:0]  workEIdx;
   logic [CNT_W-1:0]  workFCnt;
   logic [CNT_W-1:0]  workECnt;

   logic [LOC_W-1:0]  fSlotLoc;
   logic [LOC_W-1:0]  eSlotLoc;
   logic              fSlotLive;
   logic              eSlotLive;
   logic [LOC_W-1:0]  fAdj;
   logic [LOC_W-1:0]  eAdj;

   // Front offsets are computed one bit wider so the borrow/carry out of the
   // location range tells us when to clamp.
   function automatic logic [LOC_W-1:0] satSubF(input logic [LOC_W-1:0] loc);
      logic [LOC_W:0] diff;
      diff = {1'b0, loc} - (LOC_W+1)'(F_OFFSET);
      return diff[LOC_W] ? '0 : diff[LOC_W-1:0];
   endfunction

   function automatic logic [LOC_W-1:0] satAddE(input logic [LOC_W-1:0] loc);
      logic [LOC_W:0] sum;
      sum = {1'b0, loc} + (LOC_W+1)'(E_OFFSET);
      return sum[LOC_W] ? MAXLOC : sum[LOC_W-1:0];
   endfunction

   // Slot selector for the slot currently being scanned.
   always_comb begin
      fSlotLoc  = '0;
      eSlotLoc  = '0;
      fSlotLive = 1'b0;
      eSlotLive = 1'b0;
      for (int s = 0; s < N_UNITS; s++) begin
         if (scanIdx == IDX_W'(s)) begin
            fSlotLoc  = unit_loc[s*LOC_W +: LOC_W];
            eSlotLoc  = enemy_loc[s*LOC_W +: LOC_W];
            fSlotLive = |unit_type[s*TYPE_W +: TYPE_W];
            eSlotLive = |enemy_type[s*TYPE_W +: TYPE_W];
         end
      end
   end

   assign fAdj = satSubF(workMin);
   assign eAdj = satAddE(workMax);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         scanIdx        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         friendly_front <= MAXLOC;
         enemy_front    <= '0;
         friendly_idx   <= '0;
         enemy_idx      <= '0;
         friendly_cnt   <= '0;
         enemy_cnt      <= '0;
         friendly_valid <= 1'b0;
         enemy_valid    <= 1'b0;
         contact        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  workMin  <= MAXLOC;
                  workMax  <= '0;
                  workFIdx <= '0;
                  workEIdx <= '0;
                  workFCnt <= '0;
                  workECnt <= '0;
                  scanIdx  <= '0;
                  busy     <= 1'b1;
                  state    <= SCAN;
               end
            end

            // Strict compares keep the lowest slot on ties.
            SCAN: begin
               if (fSlotLive) begin
                  workFCnt <= workFCnt + CNT_W'(1);
                  if (fSlotLoc < workMin) begin
                     workMin  <= fSlotLoc;
                     workFIdx <= scanIdx;
                  end
               end
               if (eSlotLive) begin
                  workECnt <= workECnt + CNT_W'(1);
                  if (eSlotLoc > workMax) begin
                     workMax  <= eSlotLoc;
                     workEIdx <= scanIdx;
                  end
               end
               if (scanIdx == LAST_IDX) begin
                  state <= ADJUST;
               end else begin
                  scanIdx <= scanIdx + IDX_W'(1);
               end
            end

            // All result registers move together on this edge.
            ADJUST: begin
               friendly_front <= fAdj;
               enemy_front    <= eAdj;
               contact        <= (fAdj <= eAdj);
               friendly_idx   <= workFIdx;
               enemy_idx      <= workEIdx;
               friendly_cnt   <= workFCnt;
               enemy_cnt      <= workECnt;
               friendly_valid <= (workFCnt != '0);
               enemy_valid    <= (workECnt != '0);
               busy           <= 1'b0;
               done           <= 1'b1;
               state          <= DONE;
            end

            DONE: begin
               if (ack) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_battle_front_scan.sv
module tb_battle_front_scan;

   localparam int N  = 16;
   localparam int LW = 9;
   localparam int TW = 2;
   localparam int IW = $clog2(N);
   localparam int CW = $clog2(N + 1);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            ack = 1'b0;
   logic [N*LW-1:0] unit_loc = '0;
   logic [N*TW-1:0] unit_type = '0;
   logic [N*LW-1:0] enemy_loc = '0;
   logic [N*TW-1:0] enemy_type = '0;
   logic [LW-1:0]   friendly_front, enemy_front;
   logic [IW-1:0]   friendly_idx, enemy_idx;
   logic [CW-1:0]   friendly_cnt, enemy_cnt;
   logic            friendly_valid, enemy_valid, contact, busy, done;

   battle_front_scan dut (
      .clk(clk), .rst(rst), .start(start), .ack(ack),
      .unit_loc(unit_loc), .unit_type(unit_type),
      .enemy_loc(enemy_loc), .enemy_type(enemy_type),
      .friendly_front(friendly_front), .enemy_front(enemy_front),
      .friendly_idx(friendly_idx), .enemy_idx(enemy_idx),
      .friendly_cnt(friendly_cnt), .enemy_cnt(enemy_cnt),
      .friendly_valid(friendly_valid), .enemy_valid(enemy_valid),
      .contact(contact), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N*LW-1:0] uLoc;
      logic [N*TW-1:0] uType;
      logic [N*LW-1:0] eLoc;
      logic [N*TW-1:0] eType;
      int ff, fi, fc, ef, ei, ec, ct;
   } vec_t;

   vec_t vecs[7];
   int   nChecks = 0;
   int   nFail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Empty friendly slots sit at 0 and empty enemy slots at MAXLOC, so a
   // design that ignores the type field would pick them up as fronts.
   function automatic vec_t blank();
      vec_t v;
      v.uLoc = '0;  v.uType = '0;
      v.eLoc = '1;  v.eType = '0;
      v.ff = 0; v.fi = 0; v.fc = 0; v.ef = 0; v.ei = 0; v.ec = 0; v.ct = 0;
      return v;
   endfunction

   function automatic vec_t setF(input vec_t v, input int s, input int loc, input int t);
      v.uLoc[s*LW +: LW]  = LW'(loc);
      v.uType[s*TW +: TW] = TW'(t);
      return v;
   endfunction

   function automatic vec_t setE(input vec_t v, input int s, input int loc, input int t);
      v.eLoc[s*LW +: LW]  = LW'(loc);
      v.eType[s*TW +: TW] = TW'(t);
      return v;
   endfunction

   function automatic vec_t setExp(input vec_t v, input int ff, input int fi, input int fc,
                                   input int ef, input int ei, input int ec, input int ct);
      v.ff = ff; v.fi = fi; v.fc = fc; v.ef = ef; v.ei = ei; v.ec = ec; v.ct = ct;
      return v;
   endfunction

   task automatic checkResults(input vec_t v, input string tag);
      check({tag, ".friendly_front"}, 32'(friendly_front), v.ff);
      check({tag, ".friendly_idx"},   32'(friendly_idx),   v.fi);
      check({tag, ".friendly_cnt"},   32'(friendly_cnt),   v.fc);
      check({tag, ".friendly_valid"}, 32'(friendly_valid), (v.fc != 0) ? 1 : 0);
      check({tag, ".enemy_front"},    32'(enemy_front),    v.ef);
      check({tag, ".enemy_idx"},      32'(enemy_idx),      v.ei);
      check({tag, ".enemy_cnt"},      32'(enemy_cnt),      v.ec);
      check({tag, ".enemy_valid"},    32'(enemy_valid),    (v.ec != 0) ? 1 : 0);
      check({tag, ".contact"},        32'(contact),        v.ct);
      check({tag, ".done"},           32'(done),           1);
   endtask

   task automatic checkReset(input string tag);
      vec_t r;
      r = setExp(blank(), 511, 0, 0, 0, 0, 0, 0);
      check({tag, ".friendly_front"}, 32'(friendly_front), r.ff);
      check({tag, ".enemy_front"},    32'(enemy_front),    r.ef);
      check({tag, ".idx"},            32'({friendly_idx, enemy_idx}), 0);
      check({tag, ".cnt"},            32'({friendly_cnt, enemy_cnt}), 0);
      check({tag, ".valid"},          32'({friendly_valid, enemy_valid}), 0);
      check({tag, ".contact"},        32'(contact), 0);
      check({tag, ".busy"},           32'(busy), 0);
      check({tag, ".done"},           32'(done), 0);
   endtask

   task automatic loadInputs(input vec_t v);
      unit_loc   = v.uLoc;
      unit_type  = v.uType;
      enemy_loc  = v.eLoc;
      enemy_type = v.eType;
   endtask

   // Latency counts rising edges from the one that samples start up to the
   // one after which done is seen high. pokeAt>0 re-pulses start mid-scan.
   task automatic runScan(input vec_t v, input string tag, input int pokeAt, input logic withAck);
      int edges;
      int busyCycles;
      loadInputs(v);
      start = 1'b1;
      ack   = withAck;
      step();
      start = 1'b0;
      ack   = 1'b0;
      edges = 1;
      busyCycles = busy ? 1 : 0;
      while (!done && edges < 100) begin
         start = (edges == pokeAt);
         step();
         start = 1'b0;
         edges++;
         if (busy) busyCycles++;
      end
      check({tag, ".latency"}, edges, N + 2);
      check({tag, ".busy_cycles"}, busyCycles, N + 1);
      checkResults(v, tag);
   endtask

   task automatic doAck(input string tag);
      ack = 1'b1;
      step();
      ack = 1'b0;
      check({tag, ".done_after_ack"}, 32'(done), 0);
   endtask

   initial begin
      vec_t v;
      vec_t snap;
      int   stable;

      // All empty: raw fronts are the towers, offsets still apply.
      vecs[0] = setExp(blank(), 505, 0, 0, 7, 0, 0, 0);

      // Slots 0 and 15 used, friendly tie at 150 resolved to slot 9.
      v = blank();
      v = setF(v, 3, 200, 1);  v = setF(v, 9, 150, 2);  v = setF(v, 12, 150, 3);
      v = setE(v, 0, 40, 1);   v = setE(v, 15, 120, 2);
      vecs[1] = setExp(v, 144, 9, 3, 127, 15, 2, 0);

      // Both offsets saturate.
      v = blank();
      v = setF(v, 0, 3, 1);  v = setE(v, 5, 508, 3);
      vecs[2] = setExp(v, 0, 0, 1, 511, 5, 1, 1);

      // Contact without saturation.
      v = blank();
      v = setF(v, 7, 130, 2);  v = setE(v, 2, 120, 1);
      vecs[3] = setExp(v, 124, 7, 1, 127, 2, 1, 1);

      // Offsets land exactly on 0 and MAXLOC; enemy tie keeps slot 0.
      v = blank();
      v = setF(v, 15, 6, 1);  v = setE(v, 0, 504, 1);  v = setE(v, 8, 504, 2);
      vecs[4] = setExp(v, 0, 15, 1, 511, 0, 2, 1);

      // Friendly only.
      v = blank();
      v = setF(v, 1, 300, 3);
      vecs[5] = setExp(v, 294, 1, 1, 7, 0, 0, 0);

      // Every slot live on both sides.
      v = blank();
      for (int i = 0; i < N; i++) begin
         v = setF(v, i, 100 + 10*i, (i % 3) + 1);
         v = setE(v, i, 50 + i, ((i + 1) % 3) + 1);
      end
      vecs[6] = setExp(v, 94, 0, 16, 72, 15, 16, 0);

      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checkReset("reset");

      for (int k = 0; k < 7; k++) begin
         runScan(vecs[k], $sformatf("vec%0d", k), 0, 1'b0);
         doAck($sformatf("vec%0d", k));
      end

      // start re-pulsed mid-scan is ignored.
      runScan(vecs[1], "poke", 5, 1'b0);

      // Results and done hold with ack low, even if inputs move afterwards.
      loadInputs(vecs[2]);
      snap = vecs[1];
      stable = 0;
      for (int c = 0; c < 50; c++) begin
         step();
         if (done && friendly_front == LW'(snap.ff) && enemy_front == LW'(snap.ef) &&
             friendly_cnt == CW'(snap.fc) && contact == 1'(snap.ct))
            stable++;
      end
      check("hold.stable_cycles", stable, 50);

      // start with ack in DONE: back to IDLE, no new scan.
      start = 1'b1;
      ack   = 1'b1;
      step();
      start = 1'b0;
      ack   = 1'b0;
      check("startack_done.done", 32'(done), 0);
      step();
      step();
      step();
      check("startack_done.busy_later", 32'(busy), 0);
      check("startack_done.done_later", 32'(done), 0);

      // start with ack in IDLE: the scan runs.
      runScan(vecs[3], "startack_idle", 0, 1'b1);
      doAck("startack_idle");

      // Reset mid-scan discards everything.
      loadInputs(vecs[1]);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 4; c++) step();
      check("midscan.busy_before_rst", 32'(busy), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkReset("midscan_rst");
      runScan(vecs[2], "after_rst", 0, 1'b0);
      doAck("after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
      $finish;
   end

endmodule
